// File: rtl/hmmiop_stim_pkg.sv
// Shared types and constants for the HMMIOP stimulus sequencer.
// Phase-table entry layout is {rst, pb1, sw, count}, MSB first.
package hmmiop_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic        IDLE_RST         = 1'b1;
    localparam logic        IDLE_PB1         = 1'b1;
    localparam logic [15:0] DEFAULT_SIG_POLY = 16'h8016;

    function automatic int ent_w(input int sw_w, input int cnt_w);
        return 2 + sw_w + cnt_w;
    endfunction

    function automatic int sw_lsb(input int cnt_w);
        return cnt_w;
    endfunction

    function automatic int pb1_bit(input int sw_w, input int cnt_w);
        return cnt_w + sw_w;
    endfunction

    function automatic int rst_bit(input int sw_w, input int cnt_w);
        return cnt_w + sw_w + 1;
    endfunction

endpackage

// File: rtl/hmmiop_stim_sequencer_misr.sv
// Multiple-input signature register compacting the DUT LED bus.
// Clear has priority over enable.
module stim_misr
    import hmmiop_stim_pkg::*;
#(
    parameter int              SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEFAULT_SIG_POLY)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [SIG_W-1:0] i_din,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_nxt;

    always_comb begin
        w_sig_nxt = r_sig;
        if (i_clr) begin
            w_sig_nxt = '0;
        end else if (i_en) begin
            w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? SIG_POLY : '0)
                      ^ i_din;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sig <= '0;
        end else begin
            r_sig <= w_sig_nxt;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/hmmiop_stim_sequencer.sv
// Table-driven Reset/PB1/SW stimulus sequencer for the cjbRISC HMMIOP
// processor, with looping, abort and an LED signature.
module hmmiop_stim_sequencer
    import hmmiop_stim_pkg::*;
#(
    parameter int               SW_W       = 4,
    parameter int               LED_W      = 8,
    parameter int               NUM_PHASES = 4,
    parameter int               CNT_W      = 16,
    parameter int               TOT_W      = 24,
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] SIG_POLY   = SIG_W'(DEFAULT_SIG_POLY)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic                          i_loop_en,
    input  logic                          i_cfg_we,
    input  logic [$clog2(NUM_PHASES)-1:0] i_cfg_addr,
    input  logic [2+SW_W+CNT_W-1:0]       i_cfg_data,
    input  logic [LED_W-1:0]              i_led_in,
    output logic                          o_dut_reset,
    output logic                          o_dut_pb1,
    output logic [SW_W-1:0]               o_dut_sw,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(NUM_PHASES)-1:0] o_cur_phase,
    output logic [TOT_W-1:0]              o_cycle_cnt,
    output logic [SIG_W-1:0]              o_signature
);

    localparam int PH_W   = $clog2(NUM_PHASES);
    localparam int ENT_W  = ent_w(SW_W, CNT_W);
    localparam int SW_LSB = sw_lsb(CNT_W);
    localparam int PB_BIT = pb1_bit(SW_W, CNT_W);
    localparam int RS_BIT = rst_bit(SW_W, CNT_W);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ENT_W-1:0]  r_tab [NUM_PHASES];
    logic [CNT_W-1:0]  r_remain;
    logic [CNT_W-1:0]  w_remain_nxt;
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   w_phase_nxt;
    logic              r_dut_reset;
    logic              w_rst_nxt;
    logic              r_pb1;
    logic              w_pb1_nxt;
    logic [SW_W-1:0]   r_sw;
    logic [SW_W-1:0]   w_sw_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic [TOT_W-1:0]  r_cyc;
    logic [TOT_W-1:0]  w_cyc_nxt;

    logic              w_start_ok;
    logic              w_ld_en;
    logic [PH_W-1:0]   w_ld_idx;
    logic [ENT_W-1:0]  w_ld;
    logic              w_to_idle;
    logic [PH_W-1:0]   w_nxt_idx;
    logic [ENT_W-1:0]  w_ent0;
    logic [ENT_W-1:0]  w_entn;
    logic              w_cnt0_nz;
    logic              w_cntn_nz;
    logic              w_misr_en;
    logic [SIG_W-1:0]  w_din;

    always_comb begin
        w_nxt_idx = (r_phase == LAST_PH) ? '0 : r_phase + 1'b1;
        w_ent0    = r_tab[0];
        w_entn    = r_tab[w_nxt_idx];
        w_cnt0_nz = (w_ent0[CNT_W-1:0] != '0);
        w_cntn_nz = (w_entn[CNT_W-1:0] != '0);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_remain_nxt = r_remain;
        w_rst_nxt    = r_dut_reset;
        w_pb1_nxt    = r_pb1;
        w_sw_nxt     = r_sw;
        w_done_nxt   = r_done;
        w_cyc_nxt    = r_cyc;
        w_start_ok   = 1'b0;
        w_ld_en      = 1'b0;
        w_ld_idx     = '0;
        w_ld         = w_ent0;
        w_to_idle    = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                if (r_cyc != '1) begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_to_idle   = 1'b1;
                end else if (r_remain > CNT_W'(1)) begin
                    w_remain_nxt = r_remain - 1'b1;
                end else if (r_phase != LAST_PH && w_cntn_nz) begin
                    w_ld_en  = 1'b1;
                    w_ld_idx = w_nxt_idx;
                    w_ld     = w_entn;
                end else if (i_loop_en && w_cnt0_nz) begin
                    w_ld_en = 1'b1;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_to_idle   = 1'b1;
                end
            end
            default: begin
                if (i_start && !i_abort) begin
                    w_start_ok = 1'b1;
                    w_cyc_nxt  = '0;
                    w_to_idle  = 1'b1;
                    // Empty program: finish without entering RUN
                    if (w_cnt0_nz) begin
                        w_state_nxt = ST_RUN;
                        w_done_nxt  = 1'b0;
                        w_ld_en     = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
        endcase

        if (w_to_idle) begin
            w_phase_nxt = '0;
            w_rst_nxt   = IDLE_RST;
            w_pb1_nxt   = IDLE_PB1;
            w_sw_nxt    = '0;
        end
        if (w_ld_en) begin
            w_phase_nxt  = w_ld_idx;
            w_remain_nxt = w_ld[CNT_W-1:0];
            w_rst_nxt    = w_ld[RS_BIT];
            w_pb1_nxt    = w_ld[PB_BIT];
            w_sw_nxt     = w_ld[SW_LSB +: SW_W];
        end
        w_busy_nxt = (w_state_nxt == ST_RUN);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_remain    <= '0;
            r_dut_reset <= IDLE_RST;
            r_pb1       <= IDLE_PB1;
            r_sw        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cyc       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_remain    <= w_remain_nxt;
            r_dut_reset <= w_rst_nxt;
            r_pb1       <= w_pb1_nxt;
            r_sw        <= w_sw_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_cyc       <= w_cyc_nxt;
        end
    end

    // Writes land after this cycle's table read, so a run starting now sees old data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                r_tab[i] <= '0;
            end
        end else if (i_cfg_we && r_state != ST_RUN
                     && int'(i_cfg_addr) < NUM_PHASES) begin
            r_tab[i_cfg_addr] <= i_cfg_data;
        end
    end

    always_comb begin
        w_din = '0;
        w_din[LED_W-1:0] = i_led_in;
    end

    assign w_misr_en = r_busy && !r_dut_reset;

    stim_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY)
    ) u_misr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_misr_en),
        .i_clr (w_start_ok),
        .i_din (w_din),
        .o_sig (o_signature)
    );

    assign o_dut_reset = r_dut_reset;
    assign o_dut_pb1   = r_pb1;
    assign o_dut_sw    = r_sw;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_cur_phase = r_phase;
    assign o_cycle_cnt = r_cyc;

endmodule
